accum_seq: RTL and testbench

Sequential multi-operand accumulator that sits directly downstream of the n-bit adder stage. It accepts a batch of `len` operands over a valid/ready handshake and sums them into an N-bit register, one per cycle. It keeps sticky unsigned-carry and signed-overflow flags, then presents the total on a valid/ready output port.

---
 rtl/accum_seq.sv | 115 +++++++++++
 tb/tb_accum_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_seq.sv
// Sequential multi-operand accumulator: sums a batch of `len` operands one per
// accepted handshake, tracking sticky unsigned-carry and signed-overflow flags.

module accum_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] acc,
  input  logic [N-1:0] x,
  output logic [N-1:0] sum,
  output logic         c,
  output logic         v
);
  logic [N:0] wide;

  assign wide = {1'b0, acc} + {1'b0, x};
  assign sum  = wide[N-1:0];
  assign c    = wide[N];
  // Signed overflow: operands agree in sign but the result does not.
  assign v    = (acc[N-1] == x[N-1]) & (sum[N-1] != acc[N-1]);
endmodule

module accum_seq #(
  parameter int N     = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     X,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     S,
  output logic             carryout,
  output logic             overflow,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     acc;
  logic [CNT_W-1:0] cnt;
  logic             c_flag, v_flag;

  logic [N-1:0]     step_sum;
  logic             step_c, step_v;
  logic             clr, take;

  accum_step #(.N(N)) u_step (
    .acc (acc),
    .x   (X),
    .sum (step_sum),
    .c   (step_c),
    .v   (step_v)
  );

  // Handshake outputs come straight from the state register.
  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign S        = acc;
  assign carryout = c_flag;
  assign overflow = v_flag;

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = (len == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          take = 1'b1;
          if (cnt == CNT_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      c_flag <= 1'b0;
      v_flag <= 1'b0;
    end else if (clr) begin
      acc    <= '0;
      cnt    <= len;
      c_flag <= 1'b0;
      v_flag <= 1'b0;
    end else if (take) begin
      acc    <= step_sum;
      cnt    <= cnt - CNT_W'(1);
      c_flag <= c_flag | step_c;
      v_flag <= v_flag | step_v;
    end
  end
endmodule

// File: tb/tb_accum_seq.sv
// Directed bench for accum_seq at N=8, CNT_W=4 with hand-computed expectations.

module tb_accum_seq;
  localparam int N     = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     X;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     S;
  logic             carryout;
  logic             overflow;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  accum_seq #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .carryout  (carryout),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_batch(input logic [CNT_W-1:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [N-1:0] x);
    in_valid = 1'b1;
    X        = x;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; X = '0; out_ready = 1'b0;
    #12;
    n_cmp++;
    if ({S, carryout, overflow, out_valid, in_ready, busy} !== {8'd0, 5'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got S=%0d c=%b v=%b ov=%b ir=%b busy=%b, want all 0",
               S, carryout, overflow, out_valid, in_ready, busy);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    begin_batch(4'd3);
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL basic_enter_acc: in_ready=%b busy=%b, want 1 1", in_ready, busy);
    end
    in_valid = 1'b1;
    X = 8'd10; tick();
    X = 8'd20; tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_early_valid: out_valid=%b, want 0", out_valid);
    end
    X = 8'd30; tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL basic_latency: out_valid=%b in_ready=%b, want 1 0", out_valid, in_ready);
    end
    n_cmp++;
    if ({S, carryout, overflow} !== {8'd60, 2'b00}) begin
      n_bad++; $display("FAIL basic_sum: S=%0d c=%b v=%b, want 60 0 0", S, carryout, overflow);
    end
    release_out();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_return_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_carry();
    begin_batch(4'd2);
    feed(8'd200);
    feed(8'd100);
    n_cmp++;
    if ({out_valid, S, carryout, overflow} !== {1'b1, 8'd44, 2'b10}) begin
      n_bad++; $display("FAIL carry: ov=%b S=%0d c=%b v=%b, want 1 44 1 0",
                        out_valid, S, carryout, overflow);
    end
    release_out();
  endtask

  task automatic test_overflow();
    begin_batch(4'd3);
    feed(8'd100);
    feed(8'd50);
    n_cmp++;
    if ({S, carryout, overflow} !== {8'h96, 2'b01}) begin
      n_bad++; $display("FAIL ovf_step2: S=%h c=%b v=%b, want 96 0 1", S, carryout, overflow);
    end
    feed(8'h80);
    n_cmp++;
    if ({out_valid, S, carryout, overflow} !== {1'b1, 8'h16, 2'b11}) begin
      n_bad++; $display("FAIL ovf_sticky: ov=%b S=%h c=%b v=%b, want 1 16 1 1",
                        out_valid, S, carryout, overflow);
    end
    release_out();
  endtask

  task automatic test_zero_len();
    begin_batch(4'd0);
    n_cmp++;
    if ({out_valid, S, carryout, overflow} !== {1'b1, 8'd0, 2'b00}) begin
      n_bad++; $display("FAIL zero_len: ov=%b S=%0d c=%b v=%b, want 1 0 0 0",
                        out_valid, S, carryout, overflow);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({out_valid, busy, S, carryout, overflow} !== {2'b11, 8'd0, 2'b00}) begin
        n_bad++; $display("FAIL backpressure_hold[%0d]: ov=%b busy=%b S=%0d c=%b v=%b, want 1 1 0 0 0",
                          i, out_valid, busy, S, carryout, overflow);
      end
    end
    release_out();
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL zero_len_release: busy=%b ov=%b, want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_gaps();
    // Operand offered in IDLE must not leak into the next batch.
    feed(8'd99);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_in_valid: busy=%b, want 0", busy);
    end
    begin_batch(4'd2);
    feed(8'd5);
    start = 1'b1; len = 4'd9;
    tick();
    start = 1'b0;
    tick();
    n_cmp++;
    if ({in_ready, out_valid, S} !== {2'b10, 8'd5}) begin
      n_bad++; $display("FAIL gap_hold: ir=%b ov=%b S=%0d, want 1 0 5", in_ready, out_valid, S);
    end
    feed(8'd7);
    n_cmp++;
    if ({out_valid, S, carryout, overflow} !== {1'b1, 8'd12, 2'b00}) begin
      n_bad++; $display("FAIL gap_sum: ov=%b S=%0d c=%b v=%b, want 1 12 0 0",
                        out_valid, S, carryout, overflow);
    end
  endtask

  task automatic test_back_to_back();
    // Still in DONE from the previous task: start with the handshake is ignored.
    out_ready = 1'b1; start = 1'b1; len = 4'd1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL b2b_start_ignored: busy=%b, want 0", busy);
    end
    tick();
    start = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || S !== 8'd0) begin
      n_bad++; $display("FAIL b2b_next_start: ir=%b S=%0d, want 1 0", in_ready, S);
    end
    feed(8'd4);
    n_cmp++;
    if ({out_valid, S} !== {1'b1, 8'd4}) begin
      n_bad++; $display("FAIL b2b_sum: ov=%b S=%0d, want 1 4", out_valid, S);
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    begin_batch(4'd4);
    feed(8'd9);
    feed(8'd9);
    n_cmp++;
    if (S !== 8'd18 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL mid_partial: S=%0d ir=%b, want 18 1", S, in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({S, busy, in_ready} !== {8'd0, 2'b00}) begin
      n_bad++; $display("FAIL mid_reset: S=%0d busy=%b ir=%b, want 0 0 0", S, busy, in_ready);
    end
    #4 rst_n = 1'b1;
    tick();
    begin_batch(4'd1);
    feed(8'd3);
    n_cmp++;
    if ({out_valid, S, carryout, overflow} !== {1'b1, 8'd3, 2'b00}) begin
      n_bad++; $display("FAIL after_reset: ov=%b S=%0d c=%b v=%b, want 1 3 0 0",
                        out_valid, S, carryout, overflow);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_overflow();
    test_zero_len();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
